// File: rtl/mem_multiport_sync.sv
// Multi-port synchronous RAM with byte-lane writes, highest-port-wins collisions,
// selectable read-during-write behaviour, optional output register and post-reset zero sweep.
module mem_multiport_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ABITS       = 8,
  parameter int unsigned NWR         = 2,
  parameter int unsigned NRD         = 2,
  parameter int unsigned BEW         = 8,
  parameter int unsigned TRANSPARENT = 0,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned INIT_CLEAR  = 1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [NWR*(WIDTH/BEW)-1:0]     WR_WEN,
  input  logic [NWR*ABITS-1:0]           WR_ADDR,
  input  logic [NWR*WIDTH-1:0]           WR_DATA,
  input  logic [NRD-1:0]                 RD_EN,
  input  logic [NRD*ABITS-1:0]           RD_ADDR,
  output logic [NRD*WIDTH-1:0]           RD_DATA,
  output logic [NRD-1:0]                 RD_VALID,
  output logic                           INIT_BUSY
);

  localparam int unsigned NBE   = WIDTH / BEW;
  localparam int unsigned DEPTH = 2 ** ABITS;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e             state_q, state_d;
  logic [ABITS:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               run, clearing;
  logic [NRD*WIDTH-1:0] rd_word;
  logic [NRD*WIDTH-1:0] s1_data, out_data;
  logic [NRD-1:0]       s1_valid, out_valid;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= (INIT_CLEAR != 0) ? StClear : StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sweep one address per cycle, leave after the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == (ABITS+1)'(DEPTH - 1)) begin
        state_d = StRun;
      end
    end
  end

  // Outputs of the controller
  always_comb begin
    run       = RST_N && (state_q == StRun);
    clearing  = RST_N && (state_q == StClear);
    INIT_BUSY = RST_N ? (state_q == StClear) : (INIT_CLEAR != 0);
  end

  // Later ports overwrite earlier ones in the same slot, so the highest port wins
  always_ff @(posedge CLK) begin
    if (clearing) begin
      mem[cnt_q[ABITS-1:0]] <= '0;
    end else if (run) begin
      for (int unsigned p = 0; p < NWR; p++) begin
        for (int unsigned b = 0; b < NBE; b++) begin
          if (WR_WEN[p*NBE + b]) begin
            mem[WR_ADDR[p*ABITS +: ABITS]][b*BEW +: BEW] <= WR_DATA[p*WIDTH + b*BEW +: BEW];
          end
        end
      end
    end
  end

  // Read mux with optional per-lane forwarding of this cycle's merged writes
  always_comb begin
    rd_word = '0;
    for (int unsigned r = 0; r < NRD; r++) begin
      rd_word[r*WIDTH +: WIDTH] = mem[RD_ADDR[r*ABITS +: ABITS]];
      if (TRANSPARENT != 0) begin
        for (int unsigned p = 0; p < NWR; p++) begin
          for (int unsigned b = 0; b < NBE; b++) begin
            if (WR_WEN[p*NBE + b] &&
                (WR_ADDR[p*ABITS +: ABITS] == RD_ADDR[r*ABITS +: ABITS])) begin
              rd_word[r*WIDTH + b*BEW +: BEW] = WR_DATA[p*WIDTH + b*BEW +: BEW];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_data  <= '0;
      s1_valid <= '0;
    end else begin
      for (int unsigned r = 0; r < NRD; r++) begin
        s1_valid[r] <= run && RD_EN[r];
        if (run && RD_EN[r]) begin
          s1_data[r*WIDTH +: WIDTH] <= rd_word[r*WIDTH +: WIDTH];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        out_data  <= '0;
        out_valid <= '0;
      end else begin
        out_valid <= s1_valid;
        for (int unsigned r = 0; r < NRD; r++) begin
          if (s1_valid[r]) begin
            out_data[r*WIDTH +: WIDTH] <= s1_data[r*WIDTH +: WIDTH];
          end
        end
      end
    end
  end else begin : g_no_out_reg
    assign out_data  = s1_data;
    assign out_valid = s1_valid;
  end

  // Results in flight when reset falls never reach the consumer
  assign RD_DATA  = RST_N ? out_data : '0;
  assign RD_VALID = RST_N ? out_valid : '0;

endmodule

// File: tb/tb_mem_multiport_sync.sv
// Bench for mem_multiport_sync: a default instance (clear sweep, old-data reads) and a
// 16-bit, 4W/3R, transparent, output-registered, no-clear instance against an array model.
module tb_mem_multiport_sync;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  logic [1:0]  a_wen;
  logic [15:0] a_waddr, a_wdata, a_raddr, a_rdata;
  logic [1:0]  a_ren, a_rvalid;
  logic        a_busy;

  logic [7:0]  b_wen;
  logic [31:0] b_waddr;
  logic [63:0] b_wdata;
  logic [2:0]  b_ren, b_rvalid;
  logic [23:0] b_raddr;
  logic [47:0] b_rdata;
  logic        b_busy;

  mem_multiport_sync dut_a (
    .CLK(CLK), .RST_N(RST_N), .WR_WEN(a_wen), .WR_ADDR(a_waddr), .WR_DATA(a_wdata),
    .RD_EN(a_ren), .RD_ADDR(a_raddr), .RD_DATA(a_rdata), .RD_VALID(a_rvalid),
    .INIT_BUSY(a_busy)
  );

  mem_multiport_sync #(
    .WIDTH(16), .ABITS(8), .NWR(4), .NRD(3), .BEW(8),
    .TRANSPARENT(1), .OUT_REG(1), .INIT_CLEAR(0)
  ) dut_b (
    .CLK(CLK), .RST_N(RST_N), .WR_WEN(b_wen), .WR_ADDR(b_waddr), .WR_DATA(b_wdata),
    .RD_EN(b_ren), .RD_ADDR(b_raddr), .RD_DATA(b_rdata), .RD_VALID(b_rvalid),
    .INIT_BUSY(b_busy)
  );

  int checks, failures;

  // Reference state
  logic [7:0]  ma [256];
  logic [15:0] mb [256];
  int          a_clear_left;
  logic [15:0] ea_data;
  logic [1:0]  ea_valid;
  logic [47:0] eb_data, bs1_data;
  logic [2:0]  eb_valid, bs1_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_wen = '0; a_ren = '0; b_wen = '0; b_ren = '0;
  endtask

  // One clock: update the model from the driven inputs, then compare after the edge
  task automatic step();
    if (!RST_N) begin
      a_clear_left = 256;
      ea_data = '0; ea_valid = '0;
      eb_data = '0; eb_valid = '0; bs1_data = '0; bs1_valid = '0;
    end else begin
      if (a_clear_left > 0) begin
        ma[8'(256 - a_clear_left)] = 8'h00;
        a_clear_left--;
        ea_valid = '0;
      end else begin
        for (int r = 0; r < 2; r++) begin
          ea_valid[r] = a_ren[r];
          if (a_ren[r]) ea_data[r*8 +: 8] = ma[a_raddr[r*8 +: 8]];
        end
        for (int p = 0; p < 2; p++)
          if (a_wen[p]) ma[a_waddr[p*8 +: 8]] = a_wdata[p*8 +: 8];
      end
      for (int p = 0; p < 4; p++)
        for (int l = 0; l < 2; l++)
          if (b_wen[p*2 + l]) mb[b_waddr[p*8 +: 8]][l*8 +: 8] = b_wdata[p*16 + l*8 +: 8];
      for (int r = 0; r < 3; r++)
        if (bs1_valid[r]) eb_data[r*16 +: 16] = bs1_data[r*16 +: 16];
      eb_valid = bs1_valid;
      for (int r = 0; r < 3; r++) begin
        bs1_valid[r] = b_ren[r];
        if (b_ren[r]) bs1_data[r*16 +: 16] = mb[b_raddr[r*8 +: 8]];
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    check("a_rd_data", 64'(a_rdata), 64'(ea_data));
    check("a_rd_valid", 64'(a_rvalid), 64'(ea_valid));
    check("a_init_busy", 64'(a_busy), 64'((!RST_N) || (a_clear_left > 0)));
    check("b_rd_data", 64'(b_rdata), 64'(eb_data));
    check("b_rd_valid", 64'(b_rvalid), 64'(eb_valid));
    check("b_init_busy", 64'(b_busy), 64'(0));
  endtask

  task automatic run_busy(inout int n);
    while (a_busy === 1'b1 && n < 400) begin
      step();
      if (a_busy === 1'b1) n++;
    end
  endtask

  int n;

  initial begin
    checks = 0; failures = 0;
    idle();
    a_waddr = '0; a_wdata = '0; a_raddr = '0;
    b_waddr = '0; b_wdata = '0; b_raddr = '0;
    for (int i = 0; i < 256; i++) begin ma[i] = 8'h00; mb[i] = 16'h0000; end
    a_clear_left = 256;
    RST_N = 1'b0;
    @(negedge CLK);
    repeat (3) step();

    // Release; the no-clear instance is usable at once while the other sweeps
    RST_N = 1'b1;
    a_ren = 2'b11; a_raddr = 16'h7F00;
    a_wen = 2'b01; a_waddr = 16'h0005; a_wdata = 16'h00FF;
    #1;
    check("busy_at_release", 64'(a_busy), 64'(1));
    n = 1;
    b_wen = 8'hFF;
    b_waddr = {8'd4, 8'd3, 8'd2, 8'd1};
    b_wdata = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    step(); if (a_busy === 1'b1) n++;
    b_wen = '0; b_ren = 3'b111; b_raddr = {8'd4, 8'd3, 8'd1};
    step(); if (a_busy === 1'b1) n++;
    b_ren = '0;
    step(); if (a_busy === 1'b1) n++;
    check("noclear_rd_data", 64'(b_rdata), 64'(48'h0044_0033_0011));
    check("noclear_rd_valid", 64'(b_rvalid), 64'(3'b111));
    run_busy(n);
    check("clear_busy_cycles", 64'(n), 64'(256));

    idle();
    a_ren = 2'b11; a_raddr = 16'h7F00;
    step();
    check("zero_00_7f", 64'({a_rvalid, a_rdata}), 64'(18'h3_0000));
    a_raddr = 16'hFFFF;
    step();
    check("zero_ff", 64'({a_rvalid, a_rdata}), 64'(18'h3_0000));

    // Collision on one address: port 1 wins
    idle();
    a_wen = 2'b11; a_waddr = 16'h1010; a_wdata = 16'h55AA;
    step();
    idle(); a_ren = 2'b01; a_raddr = 16'h0010;
    step();
    check("collision_8b", 64'(a_rdata[7:0]), 64'(8'h55));

    // Old-data read during write
    idle(); a_wen = 2'b01; a_waddr = 16'h0020; a_wdata = 16'h0001;
    step();
    a_wdata = 16'h0002; a_ren = 2'b01; a_raddr = 16'h0020;
    step();
    check("rdw_old", 64'(a_rdata[7:0]), 64'(8'h01));
    idle(); a_ren = 2'b01;
    step();
    check("rdw_after_old", 64'(a_rdata[7:0]), 64'(8'h02));

    // Transparent read during write on the 16-bit instance
    idle(); b_wen = 8'h03; b_waddr = 32'h20; b_wdata = 64'h0001;
    step();
    b_wdata = 64'h0002; b_ren = 3'b001; b_raddr = 24'h20;
    step();
    idle();
    step();
    check("rdw_transparent", 64'({b_rvalid[0], b_rdata[15:0]}), 64'(17'h1_0002));
    b_ren = 3'b001;
    step();
    idle();
    step();
    check("rdw_after_transparent", 64'(b_rdata[15:0]), 64'(16'h0002));

    // Lane-level collision: lane 1 from port 0 only, lane 0 won by port 1
    b_wen = 8'b0000_0111; b_waddr = {8'd0, 8'd0, 8'h10, 8'h10};
    b_wdata = {32'h0, 16'hABCD, 16'h1234};
    step();
    idle(); b_ren = 3'b001; b_raddr = 24'h10;
    step();
    idle();
    step();
    check("collision_lanes", 64'(b_rdata[15:0]), 64'(16'h12CD));

    // Pipelined back-to-back reads
    b_wen = 8'hFF; b_waddr = {8'd3, 8'd2, 8'd1, 8'd0};
    b_wdata = {16'h0083, 16'h0082, 16'h0081, 16'h0080};
    step();
    b_waddr = {8'd7, 8'd6, 8'd5, 8'd4};
    b_wdata = {16'h0087, 16'h0086, 16'h0085, 16'h0084};
    step();
    idle();
    for (int i = 0; i < 10; i++) begin
      b_ren = (i < 8) ? 3'b001 : 3'b000;
      b_raddr = 24'(i);
      step();
      if (i >= 1 && i <= 8) begin
        check("pipe_valid", 64'(b_rvalid[0]), 64'(1));
        check("pipe_data", 64'(b_rdata[15:0]), 64'(16'h0080 + 16'(i - 1)));
      end
    end
    check("pipe_hold", 64'({b_rvalid[0], b_rdata[15:0]}), 64'(17'h0_0087));

    // Random traffic on a small address window to provoke collisions
    for (int k = 0; k < 400; k++) begin
      a_wen = 2'($urandom); a_ren = 2'($urandom); a_wdata = 16'($urandom);
      b_wen = 8'($urandom); b_ren = 3'($urandom); b_wdata = {$urandom, $urandom};
      for (int p = 0; p < 2; p++) begin
        a_waddr[p*8 +: 8] = 8'($urandom_range(0, 7));
        a_raddr[p*8 +: 8] = 8'($urandom_range(0, 7));
      end
      for (int p = 0; p < 4; p++) b_waddr[p*8 +: 8] = 8'($urandom_range(0, 7));
      for (int r = 0; r < 3; r++) b_raddr[r*8 +: 8] = 8'($urandom_range(0, 7));
      step();
    end

    // A read accepted just before reset falls is dropped
    idle(); a_ren = 2'b11; a_raddr = 16'h1010; b_ren = 3'b111;
    step();
    RST_N = 1'b0;
    #1;
    check("dropped_a_valid", 64'(a_rvalid), 64'(0));
    check("dropped_b_valid", 64'(b_rvalid), 64'(0));
    idle();
    step();

    // Reset in the middle of the sweep restarts it; writes during the sweep are ignored
    RST_N = 1'b1;
    a_wen = 2'b01; a_waddr = 16'h0005; a_wdata = 16'h00FF;
    repeat (100) step();
    check("busy_mid_sweep", 64'(a_busy), 64'(1));
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    #1;
    n = 1;
    run_busy(n);
    check("resweep_busy_cycles", 64'(n), 64'(256));
    idle(); a_ren = 2'b01; a_raddr = 16'h0005;
    step();
    check("sweep_write_ignored", 64'({a_rvalid[0], a_rdata[7:0]}), 64'(9'h100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
